// File: rtl/multi_clock_divider_pkg.sv
// Shared constants for the multi-channel clock divider.
// Divisors assume a 50 MHz system clock and a toggling square output.
package multi_clock_divider_pkg;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned DIV_1HZ   = 25_000_000;
    localparam int unsigned DIV_500HZ = 50_000;
    localparam int unsigned DIV_1KHZ  = 25_000;

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, active/pending divisor, tick and square out.
// Divisor changes take effect only at a wrap or a phase realign.
module div_channel #(
    parameter int unsigned     CNT_W = 26,
    parameter logic [CNT_W-1:0] INIT = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_tick,
    output logic             o_sq
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_v;
    logic             r_tick;
    logic             r_sq;

    logic             w_wrap;
    logic [CNT_W-1:0] w_next_div;

    assign w_wrap = (r_cnt == r_div - CNT_W'(1));

    // A write landing on the wrap edge wins over an older pending value.
    assign w_next_div = i_wr     ? i_val  :
                        r_pend_v ? r_pend : r_div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_div    <= INIT;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_tick   <= 1'b0;
            r_sq     <= 1'b0;
        end else if (i_clr) begin
            r_cnt    <= '0;
            r_div    <= w_next_div;
            r_pend_v <= 1'b0;
            r_tick   <= 1'b0;
            r_sq     <= 1'b0;
        end else if (i_en && w_wrap) begin
            r_cnt    <= '0;
            r_div    <= w_next_div;
            r_pend_v <= 1'b0;
            r_tick   <= 1'b1;
            r_sq     <= ~r_sq;
        end else begin
            if (i_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_wr) begin
                r_pend   <= i_val;
                r_pend_v <= 1'b1;
            end
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;

endmodule

// File: rtl/multi_clock_divider.sv
// N_CH independent clock dividers sharing one clock, with a divisor
// write port that rejects zero divisors and out-of-range channels.
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned CNT_W = 26,
    parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {
        CNT_W'(DIV_1KHZ), CNT_W'(DIV_500HZ), CNT_W'(DIV_1HZ)
    }
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_we,
    input  logic [2:0]       div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic             wr_err,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
);

    logic w_ok;
    logic r_wr_err;

    assign w_ok = div_we
               && ({1'b0, div_sel} < 4'(N_CH))
               && (div_val != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= div_we && !w_ok;
        end
    end

    assign wr_err = r_wr_err;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        logic w_wr;

        assign w_wr = w_ok && (div_sel == 3'(g));

        div_channel #(
            .CNT_W (CNT_W),
            .INIT  (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (en),
            .i_clr  (sync_clr),
            .i_wr   (w_wr),
            .i_val  (div_val),
            .o_tick (tick[g]),
            .o_sq   (sq[g])
        );
    end

endmodule
